// File: rtl/pyhdl_if_via_evq_pkg.sv
// -----------------------------------------------------------------------------
// pyhdl_if_via_evq_pkg
// Shared types for the VIA listener -> Python bridge event queue.
//   evq_kind_t   : 4-bit event kind. Codes 8..15 are reserved but legal and
//                  pass through the queue unchanged.
//   evq_entry_t  : layout of one queued entry at the default widths
//                  (ID 32 bits, sequence 16 bits). The top packs entries in
//                  the same field order {lost, seq, id, kind} for any width.
//   EVQ_DROP_CNT_W : width of the dropped-event counter.
// -----------------------------------------------------------------------------
package pyhdl_if_via_evq_pkg;

    localparam int EVQ_DROP_CNT_W = 16;
    localparam int EVQ_DFLT_ID_W  = 32;
    localparam int EVQ_DFLT_SEQ_W = 16;

    typedef enum logic [3:0] {
        EVQ_PHASE_START = 4'd0,
        EVQ_PHASE_END   = 4'd1,
        EVQ_OBJ_CREATE  = 4'd2,
        EVQ_OBJ_DESTROY = 4'd3,
        EVQ_MSG         = 4'd4,
        EVQ_USER        = 4'd5,
        EVQ_USER_6      = 4'd6,
        EVQ_USER_7      = 4'd7
    } evq_kind_t;

    typedef struct packed {
        logic                      lost;
        logic [EVQ_DFLT_SEQ_W-1:0] seq;
        logic [EVQ_DFLT_ID_W-1:0]  id;
        evq_kind_t                 kind;
    } evq_entry_t;

endpackage

// File: rtl/pyhdl_if_via_evq_mem.sv
// -----------------------------------------------------------------------------
// pyhdl_if_via_evq_mem
// DEPTH x W register array, one synchronous write port, one asynchronous
// read port. Contents are not reset; occupancy tracking lives in the top.
//   clock     : write clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_i   : read address
//   rdata_o   : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module pyhdl_if_via_evq_mem
    import pyhdl_if_via_evq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 53
) (
    input  logic                     clock,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage write port.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pyhdl_if_via_evq.sv
// -----------------------------------------------------------------------------
// pyhdl_if_via_evq
// Event queue between the VIA root listener and the Python call-out bridge.
// Each accepted notification is stamped with a wrapping sequence number,
// buffered, and presented in order on a registered valid/ready output.
//   clock, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready       : listener handshake; in_kind, in_id payload
//   flush                   : synchronous clear of all queued entries
//   out_valid/out_ready     : bridge handshake; out_kind/out_id/out_seq/out_lost
//   level                   : current occupancy
//   drop_cnt                : saturating count of discarded events
// Build option PYHDL_IF_VIA_EVQ_DROP_EN: in_ready is tied high, events that
// arrive while full are dropped and flagged on the next accepted entry.
// Without it the queue back-pressures and out_lost/drop_cnt are constant 0.
// -----------------------------------------------------------------------------
module pyhdl_if_via_evq
    import pyhdl_if_via_evq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ID_W  = 32,
    parameter int SEQ_W = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  evq_kind_t                 in_kind,
    input  logic [ID_W-1:0]           in_id,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output evq_kind_t                 out_kind,
    output logic [ID_W-1:0]           out_id,
    output logic [SEQ_W-1:0]          out_seq,
    output logic                      out_lost,
    output logic [$clog2(DEPTH):0]    level,
    output logic [EVQ_DROP_CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 1 + SEQ_W + ID_W + 4;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d, remain_s;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             out_valid_q, out_valid_d;
    evq_kind_t        out_kind_q;
    logic [ID_W-1:0]  out_id_q;
    logic [SEQ_W-1:0] out_seq_q;
    logic             out_lost_q;

    logic             pop_s, accept_s, seq_inc_s, we_s, lost_in_s;
    logic [EW-1:0]    wr_entry_s, rd_entry_s, head_s;

    assign pop_s = out_valid_q & out_ready;

`ifdef PYHDL_IF_VIA_EVQ_DROP_EN
    logic                      drop_s;
    logic                      lost_pend_q, lost_pend_d;
    logic [EVQ_DROP_CNT_W-1:0] drop_q, drop_d;

    // Accept/drop decision; a pop frees the slot a same-cycle push needs.
    // During flush every offered event is consumed (and discarded).
    always_comb begin
        accept_s  = in_valid & (flush | (level_q != LW'(DEPTH)) | pop_s);
        drop_s    = in_valid & ~accept_s;
        seq_inc_s = in_valid;
        lost_in_s = lost_pend_q;
        if (drop_s) begin
            lost_pend_d = 1'b1;
        end else if (accept_s && !flush) begin
            lost_pend_d = 1'b0;
        end else begin
            lost_pend_d = lost_pend_q;
        end
        if (drop_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Drop counter and pending-lost flag; both survive flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q      <= 16'd0;
            lost_pend_q <= 1'b0;
        end else begin
            drop_q      <= drop_d;
            lost_pend_q <= lost_pend_d;
        end
    end

    assign in_ready = 1'b1;
    assign drop_cnt = drop_q;
`else
    logic in_ready_q;

    // Back-pressure mode: acceptance depends only on registered state.
    always_comb begin
        accept_s  = in_valid & in_ready_q;
        seq_inc_s = accept_s;
        lost_in_s = 1'b0;
    end

    // in_ready is registered from next-cycle occupancy, so no path from out_ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (level_d != LW'(DEPTH));
        end
    end

    assign in_ready = in_ready_q;
    assign drop_cnt = 16'd0;
`endif

    // A push during flush still consumes a sequence number but is not stored.
    assign we_s       = accept_s & ~flush;
    assign wr_entry_s = {lost_in_s, seq_q, in_id, in_kind};

    pyhdl_if_via_evq_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clock   (clock),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_s),
        .raddr_i (rd_ptr_d),
        .rdata_o (rd_entry_s)
    );

    // Pointer, level, sequence and next-head computation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (pop_s) begin
            remain_s = level_q - LW'(1);
        end else begin
            remain_s = level_q;
        end
        if (flush) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            level_d  = LW'(0);
        end else begin
            if (accept_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (accept_s && !pop_s) begin
                level_d = level_q + LW'(1);
            end else if (!accept_s && pop_s) begin
                level_d = level_q - LW'(1);
            end else begin
                level_d = level_q;
            end
        end
        if (seq_inc_s) begin
            seq_d = seq_q + SEQ_W'(1);
        end else begin
            seq_d = seq_q;
        end
        // When no older entry survives this edge, the new head is the entry
        // being written now (the storage read would still see stale data).
        if (remain_s == LW'(0)) begin
            head_s = wr_entry_s;
        end else begin
            head_s = rd_entry_s;
        end
        out_valid_d = ~flush & (level_d != LW'(0));
    end

    // Queue state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= LW'(0);
            seq_q    <= SEQ_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            seq_q    <= seq_d;
        end
    end

    // Output registers; payload holds while the queue is empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_kind_q  <= EVQ_PHASE_START;
            out_id_q    <= ID_W'(0);
            out_seq_q   <= SEQ_W'(0);
            out_lost_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (out_valid_d) begin
                out_kind_q <= evq_kind_t'(head_s[3:0]);
                out_id_q   <= head_s[ID_W+3:4];
                out_seq_q  <= head_s[SEQ_W+ID_W+3:ID_W+4];
                out_lost_q <= head_s[EW-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_kind  = out_kind_q;
    assign out_id    = out_id_q;
    assign out_seq   = out_seq_q;
    assign out_lost  = out_lost_q;
    assign level     = level_q;

endmodule

// File: tb/tb_pyhdl_if_via_evq.sv
module tb_pyhdl_if_via_evq;
    import pyhdl_if_via_evq_pkg::*;

    localparam int DEPTH = 8;
    localparam int ID_W  = 32;
    localparam int SEQ_W = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    evq_kind_t        in_kind = EVQ_PHASE_START;
    logic [ID_W-1:0]  in_id = 32'd0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    evq_kind_t        out_kind;
    logic [ID_W-1:0]  out_id;
    logic [SEQ_W-1:0] out_seq;
    logic             out_lost;
    logic [3:0]       level;
    logic [15:0]      drop_cnt;

    pyhdl_if_via_evq #(.DEPTH(DEPTH), .ID_W(ID_W), .SEQ_W(SEQ_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_id(in_id),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_id(out_id), .out_seq(out_seq), .out_lost(out_lost),
        .level(level), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: an ordered list of queued events plus counters.
    typedef struct {
        logic [3:0]  kind;
        logic [31:0] id;
        logic [15:0] seq;
        logic        lost;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_seq = 16'd0;
    int          m_drop = 0;
    bit          m_pend = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_seq  = 16'd0;
        m_drop = 0;
        m_pend = 1'b0;
    endtask

    // Apply the queue rules for one clock edge, using pre-edge model state.
    task automatic model_edge(input bit v, input logic [3:0] k, input logic [31:0] id,
                              input bit rdy, input bit fl);
        bit   do_pop;
        ent_t e;
        do_pop = (mq.size() > 0) && rdy;
`ifdef PYHDL_IF_VIA_EVQ_DROP_EN
        if (fl) begin
            if (v) m_seq = m_seq + 16'd1;
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (v) begin
                if (mq.size() < DEPTH) begin
                    e.kind = k; e.id = id; e.seq = m_seq; e.lost = m_pend;
                    mq.push_back(e);
                    m_pend = 1'b0;
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_pend = 1'b1;
                end
                m_seq = m_seq + 16'd1;
            end
        end
`else
        begin
            bit acc;
            acc = v && (mq.size() != DEPTH);
            e.kind = k; e.id = id; e.seq = m_seq; e.lost = 1'b0;
            if (acc) m_seq = m_seq + 16'd1;
            if (fl) begin
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (acc) mq.push_back(e);
            end
        end
`endif
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, mq.size() > 0);
        chk("level", level, mq.size());
`ifdef PYHDL_IF_VIA_EVQ_DROP_EN
        chk("in_ready", in_ready, 1);
`else
        chk("in_ready", in_ready, mq.size() != DEPTH);
`endif
        chk("drop_cnt", drop_cnt, m_drop);
        if (mq.size() > 0) begin
            chk("out_kind", out_kind, mq[0].kind);
            chk("out_id", out_id, mq[0].id);
            chk("out_seq", out_seq, mq[0].seq);
            chk("out_lost", out_lost, mq[0].lost);
        end
    endtask

    // One cycle: called at a negedge, drives inputs, checks at the next negedge.
    task automatic step(input bit v, input logic [3:0] k, input logic [31:0] id,
                        input bit rdy, input bit fl);
        in_valid  = v;
        in_kind   = evq_kind_t'(k);
        in_id     = id;
        out_ready = rdy;
        flush     = fl;
        @(posedge clock);
        model_edge(v, k, id, rdy, fl);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        model_clear();
    endtask

    logic [15:0] prev_seq;
    bit          saw_wrap;

    initial begin
        // Reset values
        @(negedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_kind", out_kind, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_seq", out_seq, 0);
        chk("rst_out_lost", out_lost, 0);
        chk("rst_level", level, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        reset_n = 1'b1;
        model_clear();

        // First push appears on the output one edge later
        step(1'b1, 4'd2, 32'h10, 1'b0, 1'b0);
        chk("first_valid", out_valid, 1);
        chk("first_kind", out_kind, 2);
        chk("first_id", out_id, 32'h10);
        chk("first_seq", out_seq, 0);
        chk("first_level", level, 1);

        // Fill to DEPTH with the bridge stalled, then drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 4'(i), 32'h100 + i, 1'b0, 1'b0);
        chk("full_level", level, 8);
        chk("full_hold_seq", out_seq, 0);
`ifdef PYHDL_IF_VIA_EVQ_DROP_EN
        for (int i = 0; i < 3; i++) step(1'b1, 4'd4, 32'hDEAD + i, 1'b0, 1'b0);
        chk("drop_cnt3", drop_cnt, 3);
        chk("drop_level", level, 8);
`else
        chk("full_in_ready", in_ready, 0);
        step(1'b1, 4'd4, 32'hDEAD, 1'b0, 1'b0);
        chk("full_blocked_level", level, 8);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_seq", out_seq, i);
            step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        end
        chk("drained_valid", out_valid, 0);
`ifdef PYHDL_IF_VIA_EVQ_DROP_EN
        step(1'b1, 4'd5, 32'h55, 1'b0, 1'b0);
        chk("lost_flag", out_lost, 1);
        chk("lost_seq", out_seq, 11);
        step(1'b1, 4'd6, 32'h66, 1'b1, 1'b0);
        chk("after_lost_flag", out_lost, 0);
        chk("after_lost_seq", out_seq, 12);
`endif

        // Flush with a concurrent push
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 4'd3, 32'h200 + i, 1'b0, 1'b0);
        step(1'b1, 4'd3, 32'hAB, 1'b0, 1'b1);
        chk("flush_level", level, 0);
        chk("flush_valid", out_valid, 0);
        step(1'b1, 4'd4, 32'hCD, 1'b0, 1'b0);
        chk("post_flush_seq", out_seq, 6);

        // Random traffic, reserved kinds included, occasional flush
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) step(1'b1, 4'd1, 32'h300 + i, 1'b0, 1'b0);
        chk("burst_valid", out_valid, 1);
        in_valid = 1'b1; out_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_level", level, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        model_clear();
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 4'd9, 32'h77, 1'b0, 1'b0);
        chk("post_rst_seq", out_seq, 0);
        chk("reserved_kind", out_kind, 9);

        // Sustained push+pop across a sequence wrap
        do_reset();
        saw_wrap = 1'b0;
        prev_seq = 16'd0;
        for (int n = 0; n < 65540; n++) begin
            step(1'b1, 4'($urandom_range(0, 15)), $urandom, 1'b1, 1'b0);
            if (n > 0 && prev_seq == 16'hFFFF && out_seq == 16'h0000) saw_wrap = 1'b1;
            prev_seq = out_seq;
        end
        chk("seq_wrapped", saw_wrap, 1);
        chk("stream_level", level, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
